// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED bar chaser.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_FILL   = 2'b10
  } mode_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  // The unused encoding 2'b11 behaves as BOUNCE.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_WRAP;
      2'b10:   return MODE_FILL;
      default: return MODE_BOUNCE;
    endcase
  endfunction

endpackage

// File: rtl/led_chaser_gen_tick.sv
// Free-running prescaler with a selectable tap; tick pulses when the low
// (DIV_EXP-speed) bits of the prescaler are all ones.
module tick_gen #(
  parameter int unsigned DIV_EXP = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [DIV_EXP-1:0] ONE = DIV_EXP'(1);

  logic [DIV_EXP-1:0] prescaler;
  logic [DIV_EXP-1:0] low_mask;

  // Prescaler counts only while running; it holds its value when frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prescaler <= '0;
    else if (run) prescaler <= prescaler + ONE;
  end

  // Build the mask of bits that must be all ones for the selected speed.
  always_comb begin
    low_mask = '0;
    for (int unsigned i = 0; i < DIV_EXP; i++) begin
      low_mask[i] = (i < (DIV_EXP - 32'(speed)));
    end
  end

  assign tick = &(prescaler | ~low_mask);

endmodule

// File: rtl/led_chaser_gen.sv
// LED bar chaser: bounce, wrap and fill patterns on a red/green LED row,
// advanced by the prescaler tick while running or by single steps when frozen.
module led_chaser_gen
  import led_chaser_pkg::*;
#(
  parameter int unsigned LED_W   = 8,
  parameter int unsigned BAR_LEN = 3,
  parameter int unsigned DIV_EXP = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             dir_sel,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] red_out,
  output logic [LED_W-1:0] green_out,
  output logic             ctl_bit,
  output logic             end_pulse
);

  localparam int unsigned   PW       = $clog2(LED_W + 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(LED_W - BAR_LEN);
  localparam logic [PW-1:0] POS_TOP  = PW'(LED_W - 1);
  localparam logic [PW-1:0] LVL_FULL = PW'(LED_W);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic    tick;
  logic    adv;
  mode_t   req_mode;
  mode_t   cur_mode, cur_mode_d;
  logic [PW-1:0] pos, pos_d;
  logic [PW-1:0] level, level_d;
  logic    dir, dir_d;
  logic    end_d;
  logic [LED_W-1:0] bar;

  tick_gen #(.DIV_EXP(DIV_EXP)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .speed (speed),
    .tick  (tick)
  );

  assign adv      = (run & tick) | (~run & step);
  assign req_mode = decode_mode(mode);
  assign ctl_bit  = 1'b1;

  // True when LED i lies within BAR_LEN positions above p, wrapping at LED_W.
  function automatic logic in_bar(input int unsigned i, input logic [PW-1:0] p);
    int unsigned off;
    off = i + LED_W - 32'(p);
    if (off >= LED_W) off = off - LED_W;
    return (off < BAR_LEN);
  endfunction

  // Pattern state register; reset pose is the BOUNCE start position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_mode  <= MODE_BOUNCE;
      pos       <= POS_MAX;
      dir       <= DIR_LSB;
      level     <= '0;
      end_pulse <= 1'b0;
    end else begin
      cur_mode  <= cur_mode_d;
      pos       <= pos_d;
      dir       <= dir_d;
      level     <= level_d;
      end_pulse <= end_d;
    end
  end

  // Next-state: on an advance either reload for a new mode or move one step.
  // In WRAP the dir register latches dir_sel so the colour only changes on advance.
  always_comb begin
    cur_mode_d = cur_mode;
    pos_d      = pos;
    dir_d      = dir;
    level_d    = level;
    end_d      = 1'b0;
    if (adv) begin
      if (req_mode != cur_mode) begin
        cur_mode_d = req_mode;
        pos_d      = POS_MAX;
        dir_d      = DIR_LSB;
        level_d    = '0;
      end else begin
        case (cur_mode)
          MODE_BOUNCE: begin
            if (dir == DIR_LSB) begin
              if (pos == '0) begin
                dir_d = DIR_MSB;
                pos_d = ONE;
                end_d = 1'b1;
              end else begin
                pos_d = pos - ONE;
              end
            end else begin
              if (pos == POS_MAX) begin
                dir_d = DIR_LSB;
                pos_d = POS_MAX - ONE;
                end_d = 1'b1;
              end else begin
                pos_d = pos + ONE;
              end
            end
          end
          MODE_WRAP: begin
            dir_d = dir_sel;
            if (dir_sel == DIR_LSB) begin
              if (pos == '0) begin
                pos_d = POS_TOP;
                end_d = 1'b1;
              end else begin
                pos_d = pos - ONE;
              end
            end else begin
              if (pos == POS_TOP) begin
                pos_d = '0;
                end_d = 1'b1;
              end else begin
                pos_d = pos + ONE;
              end
            end
          end
          MODE_FILL: begin
            if (level == LVL_FULL) begin
              level_d = '0;
              end_d   = 1'b1;
            end else begin
              level_d = level + ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode from registered state; bar colour follows dir.
  always_comb begin
    red_out   = '0;
    green_out = '0;
    bar       = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      bar[i] = in_bar(i, pos);
    end
    if (cur_mode == MODE_FILL) begin
      for (int unsigned i = 0; i < LED_W; i++) begin
        red_out[i]   = (i < 32'(level));
        green_out[i] = (i == 32'(level));
      end
    end else if (dir == DIR_LSB) begin
      red_out = bar;
    end else begin
      green_out = bar;
    end
  end

endmodule

// File: tb/tb_led_chaser_gen.sv
// Directed self-checking bench for led_chaser_gen (LED_W=8, BAR_LEN=3, DIV_EXP=4).
module tb_led_chaser_gen;

  localparam int unsigned LED_W   = 8;
  localparam int unsigned BAR_LEN = 3;
  localparam int unsigned DIV_EXP = 4;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       run     = 1'b0;
  logic       step    = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic       dir_sel = 1'b0;
  logic [1:0] speed   = 2'b00;
  logic [7:0] red_out;
  logic [7:0] green_out;
  logic       ctl_bit;
  logic       end_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  led_chaser_gen #(
    .LED_W   (LED_W),
    .BAR_LEN (BAR_LEN),
    .DIV_EXP (DIV_EXP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .mode      (mode),
    .dir_sel   (dir_sel),
    .speed     (speed),
    .red_out   (red_out),
    .green_out (green_out),
    .ctl_bit   (ctl_bit),
    .end_pulse (end_pulse)
  );

  // Called at a negedge; the advance lands on the following posedge.
  task automatic pulse_step;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Negedges until the LED rows change; 64 means the bound expired.
  task automatic cycles_to_change(output int n);
    logic [15:0] start;
    start = {red_out, green_out};
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if ({red_out, green_out} !== start) break;
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({red_out, green_out, end_pulse, ctl_bit} !== {8'hE0, 8'h00, 1'b0, 1'b1}) begin
      $display("FAIL reset_state: got %h/%h/%b/%b want e0/00/0/1", red_out, green_out, end_pulse, ctl_bit);
    end else pass_cnt++;
    run = 1'b1; mode = 2'b00; speed = 2'b00;
    reset = 1'b1;
    cycles_to_change(n);
    total_cnt++;
    if (n !== 16) $display("FAIL reset_first_tick: got %0d cycles want 16", n);
    else pass_cnt++;
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'h70, 8'h00, 1'b0}) begin
      $display("FAIL reset_first_pose: got %h/%h/%b want 70/00/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
  endtask

  task automatic test_bounce;
    logic [16:0] exp_tab [10];
    int extra;
    exp_tab = '{{8'h38, 8'h00, 1'b0}, {8'h1C, 8'h00, 1'b0}, {8'h0E, 8'h00, 1'b0},
                {8'h07, 8'h00, 1'b0}, {8'h00, 8'h0E, 1'b1}, {8'h00, 8'h1C, 1'b0},
                {8'h00, 8'h38, 1'b0}, {8'h00, 8'h70, 1'b0}, {8'h00, 8'hE0, 1'b0},
                {8'h70, 8'h00, 1'b1}};
    extra = 0;
    for (int t = 0; t < 10; t++) begin
      repeat (15) begin
        @(negedge clk);
        if (end_pulse) extra++;
      end
      @(negedge clk);
      total_cnt++;
      if ({red_out, green_out, end_pulse} !== exp_tab[t]) begin
        $display("FAIL bounce_tick%0d: got %h/%h/%b want %h/%h/%b", t + 2,
                 red_out, green_out, end_pulse, exp_tab[t][16:9], exp_tab[t][8:1], exp_tab[t][0]);
      end else pass_cnt++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL bounce_stray_end: got %0d stray pulses want 0", extra);
    else pass_cnt++;
    run = 1'b0;
  endtask

  task automatic test_wrap;
    logic [16:0] exp_tab [11];
    exp_tab = '{{8'h70, 8'h00, 1'b0}, {8'h38, 8'h00, 1'b0}, {8'h1C, 8'h00, 1'b0},
                {8'h0E, 8'h00, 1'b0}, {8'h07, 8'h00, 1'b0}, {8'h83, 8'h00, 1'b1},
                {8'hC1, 8'h00, 1'b0}, {8'hE0, 8'h00, 1'b0}, {8'h00, 8'hC1, 1'b0},
                {8'h00, 8'h83, 1'b0}, {8'h00, 8'h07, 1'b1}};
    mode = 2'b01; dir_sel = 1'b0;
    pulse_step;
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'hE0, 8'h00, 1'b0}) begin
      $display("FAIL wrap_reload: got %h/%h/%b want e0/00/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
    for (int t = 0; t < 11; t++) begin
      if (t == 8) dir_sel = 1'b1;
      pulse_step;
      total_cnt++;
      if ({red_out, green_out, end_pulse} !== exp_tab[t]) begin
        $display("FAIL wrap_step%0d: got %h/%h/%b want %h/%h/%b", t + 1,
                 red_out, green_out, end_pulse, exp_tab[t][16:9], exp_tab[t][8:1], exp_tab[t][0]);
      end else pass_cnt++;
    end
    repeat (10) @(negedge clk);
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'h00, 8'h07, 1'b0}) begin
      $display("FAIL wrap_hold: got %h/%h/%b want 00/07/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
  endtask

  task automatic test_fill;
    logic [8:0] ones;
    logic [7:0] er, eg;
    logic       ee;
    mode = 2'b10;
    pulse_step;
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'h00, 8'h01, 1'b0}) begin
      $display("FAIL fill_reload: got %h/%h/%b want 00/01/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
    for (int k = 1; k <= 9; k++) begin
      pulse_step;
      ones = (9'(1) << k) - 9'(1);
      er = (k == 9) ? 8'h00 : ones[7:0];
      eg = (k == 9) ? 8'h01 : ((k == 8) ? 8'h00 : (8'(1) << k));
      ee = (k == 9);
      total_cnt++;
      if ({red_out, green_out, end_pulse} !== {er, eg, ee}) begin
        $display("FAIL fill_step%0d: got %h/%h/%b want %h/%h/%b", k,
                 red_out, green_out, end_pulse, er, eg, ee);
      end else pass_cnt++;
    end
  endtask

  task automatic test_run_step;
    int n;
    run = 1'b1;
    pulse_step;
    total_cnt++;
    if ({red_out, green_out} !== {8'h00, 8'h01}) begin
      $display("FAIL step_ignored_in_run: got %h/%h want 00/01", red_out, green_out);
    end else pass_cnt++;
    cycles_to_change(n);
    total_cnt++;
    if (n !== 15) $display("FAIL run_tick_after_step: got %0d cycles want 15", n);
    else pass_cnt++;
    total_cnt++;
    if ({red_out, green_out} !== {8'h01, 8'h02}) begin
      $display("FAIL run_tick_pose: got %h/%h want 01/02", red_out, green_out);
    end else pass_cnt++;
    repeat (5) @(negedge clk);
    run = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'h01, 8'h02, 1'b0}) begin
      $display("FAIL frozen_hold: got %h/%h/%b want 01/02/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
    run = 1'b1;
    cycles_to_change(n);
    total_cnt++;
    if (n !== 11) $display("FAIL prescaler_kept: got %0d cycles want 11", n);
    else pass_cnt++;
    total_cnt++;
    if ({red_out, green_out} !== {8'h03, 8'h04}) begin
      $display("FAIL prescaler_kept_pose: got %h/%h want 03/04", red_out, green_out);
    end else pass_cnt++;
  endtask

  task automatic test_speed_mode;
    int n;
    speed = 2'b11; mode = 2'b00;
    cycles_to_change(n);
    total_cnt++;
    if (n !== 2 || {red_out, green_out, end_pulse} !== {8'he0, 8'h00, 1'b0}) begin
      $display("FAIL fast_mode_change: got %0d cycles %h/%h/%b want 2 e0/00/0", n, red_out, green_out, end_pulse);
    end else pass_cnt++;
    cycles_to_change(n);
    total_cnt++;
    if (n !== 2 || {red_out, green_out} !== {8'h70, 8'h00}) begin
      $display("FAIL fast_tick: got %0d cycles %h/%h want 2 70/00", n, red_out, green_out);
    end else pass_cnt++;
    run = 1'b0; speed = 2'b00;
    mode = 2'b10;
    pulse_step;
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'h00, 8'h01, 1'b0}) begin
      $display("FAIL bounce_to_fill: got %h/%h/%b want 00/01/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
    mode = 2'b11;
    pulse_step;
    total_cnt++;
    if ({red_out, green_out} !== {8'hE0, 8'h00}) begin
      $display("FAIL mode3_reload: got %h/%h want e0/00", red_out, green_out);
    end else pass_cnt++;
    pulse_step;
    total_cnt++;
    if ({red_out, green_out} !== {8'h70, 8'h00}) begin
      $display("FAIL mode3_moves: got %h/%h want 70/00", red_out, green_out);
    end else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    int n;
    mode = 2'b00; run = 1'b1;
    repeat (5) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    total_cnt++;
    if ({red_out, green_out, end_pulse} !== {8'hE0, 8'h00, 1'b0}) begin
      $display("FAIL midrun_reset: got %h/%h/%b want e0/00/0", red_out, green_out, end_pulse);
    end else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    cycles_to_change(n);
    total_cnt++;
    if (n !== 16 || {red_out, green_out} !== {8'h70, 8'h00}) begin
      $display("FAIL midrun_release: got %0d cycles %h/%h want 16 70/00", n, red_out, green_out);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_wrap;
    test_fill;
    test_run_step;
    test_speed_mode;
    test_reset_midrun;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
